// File: rtl/uart_pkg.sv
// Shared types and helpers for the single-channel UART transmitter.
package uart_pkg;

    // Frame sequencing states; ST_ prefix keeps them clear of parameter names.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Legal values of the string parameters.
    localparam string PAR_NO    = "NO";
    localparam string PAR_EVEN  = "EVEN";
    localparam string PAR_ODD   = "ODD";
    localparam string FIRST_LSB = "LSB";
    localparam string FIRST_MSB = "MSB";

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clock, input int baud);
        return (clock + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts DIV clocks while enabled and pulses o_tick for
// one cycle on the last clock of each bit period. i_restart re-aligns the
// period to the accepting edge of a new frame.
module uart_baud_tick #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Divide counter; held at zero while idle so the first tick lands DIV clocks after restart.
    always_ff @(posedge clk) begin
        if (reset || i_restart) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_tick = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/single_tx_uart.sv
// Single-channel UART transmitter: start bit, 8 data bits, optional parity,
// one stop bit. One byte per accepted start pulse; busy and txd registered.
module single_tx_uart
    import uart_pkg::*;
#(
    parameter int    CLOCK     = 8_000_000,
    parameter int    BAUD      = 1_000_000,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       txd
);

    localparam int DIV          = calc_div(CLOCK, BAUD);
    localparam bit PAR_EN       = (PARITY != PAR_NO);
    localparam bit PAR_ODD_MODE = (PARITY == PAR_ODD);
    localparam bit MSB_FIRST    = (FIRST_BIT == FIRST_MSB);

    // Elaboration-time parameter checks.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("single_tx_uart: CLOCK/BAUD gives fewer than 2 clocks per bit");
        end
        if (!((PARITY == PAR_NO) || (PARITY == PAR_EVEN) || (PARITY == PAR_ODD))) begin : g_bad_parity
            $error("single_tx_uart: PARITY must be NO, EVEN or ODD");
        end
        if (!((FIRST_BIT == FIRST_LSB) || (FIRST_BIT == FIRST_MSB))) begin : g_bad_first
            $error("single_tx_uart: FIRST_BIT must be LSB or MSB");
        end
    endgenerate

    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_next;
    logic        r_parity;
    logic        w_parity_next;
    logic        r_txd;
    logic        w_txd_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        w_accept;
    logic        w_tick;
    logic        w_out_bit;
    logic [7:0]  w_shift_adv;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_accept),
        .i_enable  (r_busy),
        .o_tick    (w_tick)
    );

    // Bit that goes on the line next, and the register after it is consumed.
    assign w_out_bit   = MSB_FIRST ? r_shift[7] : r_shift[0];
    assign w_shift_adv = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_txd_next     = r_txd;
        w_busy_next    = r_busy;
        w_accept       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_txd_next  = 1'b1;
                w_busy_next = 1'b0;
            end
            ST_START: begin
                if (w_tick) begin
                    w_txd_next     = w_out_bit;
                    w_shift_next   = w_shift_adv;
                    w_bit_cnt_next = 3'd0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == 3'd7) begin
                        if (PAR_EN) begin
                            w_txd_next   = r_parity;
                            w_state_next = ST_PARITY;
                        end else begin
                            w_txd_next   = 1'b1;
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_txd_next     = w_out_bit;
                        w_shift_next   = w_shift_adv;
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_txd_next   = 1'b1;
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_txd_next   = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_txd_next   = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase

        // Accept a new byte while idle, or at the very edge where busy would
        // fall, so a held start produces frames with no idle gap.
        if (start && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick))) begin
            w_accept       = 1'b1;
            w_shift_next   = tx_data;
            w_parity_next  = (^tx_data) ^ PAR_ODD_MODE;
            w_bit_cnt_next = 3'd0;
            w_txd_next     = 1'b0;
            w_busy_next    = 1'b1;
            w_state_next   = ST_START;
        end
    end

    // State, datapath and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_txd     <= w_txd_next;
            r_busy    <= w_busy_next;
        end
    end

    assign busy = r_busy;
    assign txd  = r_txd;

endmodule

// File: tb/tb_single_tx_uart.sv
// Bench for single_tx_uart: four parameter variants driven in parallel and
// checked cycle-by-cycle against a frame model built from the line format.
module tb_single_tx_uart;

    localparam int DIV   = 8;           // 8 MHz / 1 Mbaud
    localparam int NINST = 4;
    localparam int WIN   = 2 * 11 * DIV + 4;

    // Variant table: 0 LSB/NO, 1 MSB/NO, 2 LSB/EVEN, 3 MSB/ODD (0=NO,1=EVEN,2=ODD)
    localparam bit [NINST-1:0] CFG_MSB = 4'b1010;
    int cfg_par [NINST] = '{0, 0, 1, 2};

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [7:0]       tx_data;
    logic [NINST-1:0] busy_v;
    logic [NINST-1:0] txd_v;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    single_tx_uart #(.PARITY("NO"),   .FIRST_BIT("LSB")) dut_lsb_no (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .busy(busy_v[0]), .txd(txd_v[0]));
    single_tx_uart #(.PARITY("NO"),   .FIRST_BIT("MSB")) dut_msb_no (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .busy(busy_v[1]), .txd(txd_v[1]));
    single_tx_uart #(.PARITY("EVEN"), .FIRST_BIT("LSB")) dut_lsb_even (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .busy(busy_v[2]), .txd(txd_v[2]));
    single_tx_uart #(.PARITY("ODD"),  .FIRST_BIT("MSB")) dut_msb_odd (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .busy(busy_v[3]), .txd(txd_v[3]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line-level frame: start 0, data in wire order, optional parity, stop 1.
    function automatic void frame_model(input logic [7:0] b, input bit msb, input int par,
                                        output logic [10:0] bits, output int n);
        int ones;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = msb ? b[7 - i] : b[i];
        ones = $countones(b);
        if (par != 0) begin
            bits[9] = ((ones % 2) == 1) ? (par == 1) : (par == 2);
            n = 11;
        end else begin
            n = 10;
        end
    endfunction

    task automatic check_idle(input string tag);
        for (int k = 0; k < NINST; k++) begin
            check_val($sformatf("%s_txd%0d", tag, k), 32'(txd_v[k]), 32'd1);
            check_val($sformatf("%s_busy%0d", tag, k), 32'(busy_v[k]), 32'd0);
        end
    endtask

    // Launch one start (held until drop_c), then compare every cycle of the
    // window. nfr = frames expected per variant; poke = ignored mid-frame start;
    // rst_at >= 0 asserts reset at that cycle and ends the run after checking.
    task automatic run_frame(input logic [7:0] b, input int nfr, input int drop_c,
                             input bit poke, input int rst_at);
        logic [10:0] bits [NINST];
        int          nb   [NINST];
        int          flen, f;
        logic        exp_txd, exp_busy;
        for (int k = 0; k < NINST; k++) frame_model(b, CFG_MSB[k], cfg_par[k], bits[k], nb[k]);
        @(negedge clk);
        start   = 1'b1;
        tx_data = b;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            for (int k = 0; k < NINST; k++) begin
                flen = nb[k] * DIV;
                f    = c / flen;
                if ((rst_at >= 0) && (c > rst_at)) begin
                    exp_txd  = 1'b1;
                    exp_busy = 1'b0;
                end else if (f < nfr) begin
                    exp_txd  = bits[k][(c % flen) / DIV];
                    exp_busy = 1'b1;
                end else begin
                    exp_txd  = 1'b1;
                    exp_busy = 1'b0;
                end
                check_val($sformatf("txd%0d_c%0d", k, c), 32'(txd_v[k]), 32'(exp_txd));
                check_val($sformatf("busy%0d_c%0d", k, c), 32'(busy_v[k]), 32'(exp_busy));
            end
            if (c == drop_c) start = 1'b0;
            if (nfr == 1 && c == 5) tx_data = 8'($urandom);
            if (poke && c == 20) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end
            if (poke && c == 21) start = 1'b0;
            if (rst_at >= 0 && c == rst_at) reset = 1'b1;
            if (rst_at >= 0 && c == rst_at + 1) begin
                reset = 1'b0;
                break;
            end
        end
        start = 1'b0;
        $display("frame byte=%02h frames=%0d poke=%0d rst_at=%0d checks=%0d bad=%0d",
                 b, nfr, poke, rst_at, n_checks, n_bad);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        run_frame(8'h43, 1, 0, 1'b0, -1);   // basic frame, all variants
        run_frame(8'h43, 1, 0, 1'b1, -1);   // ignored start during frame
        run_frame(8'hA7, 1, 0, 1'b0, 30);   // reset during DATA
        check_idle("after_abort");
        run_frame(8'h43, 1, 0, 1'b0, -1);   // clean frame after abort
        run_frame(8'h55, 2, 120, 1'b0, -1); // start held: back-to-back frames
        run_frame(8'h00, 1, 0, 1'b0, -1);
        run_frame(8'hFF, 1, 0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), 1, 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
